// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, vector memory waits.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_DELAY  = 1,
    parameter int unsigned BR_PENALTY  = 2,
    parameter int unsigned VEC_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] id_rp,
    input  logic [3:0] id_rs,
    input  logic       id_use_rp,
    input  logic       id_use_rs,
    input  logic [3:0] ex_rg,
    input  logic       ex_load,
    input  logic       ex_taken,
    input  logic       ex_vec_mem,
    input  logic       vec_done,
    output logic       sel_sto,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       flush_if_id,
    output logic       bubble_ex,
    output logic       vec_start,
    output logic       vec_err,
    output logic [1:0] state_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stat_stall,
    output logic [15:0] stat_flush
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        VWAIT  = 2'd3
    } state_t;

    localparam logic [7:0] LD_M1 = 8'(LOAD_DELAY - 1);
    localparam logic [7:0] BP_M1 = 8'(BR_PENALTY - 1);
    localparam logic [7:0] TO_M1 = 8'(VEC_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_set;
    logic       hz;
    logic       sel_c, stall_c, flush_c, bubble_c, start_c;

    assign hz = ex_load & ((id_use_rp & (id_rp == ex_rg)) |
                           (id_use_rs & (id_rs == ex_rg)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_set  = 1'b0;
        sel_c    = 1'b0;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        bubble_c = 1'b0;
        start_c  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (ex_taken) begin
                    sel_c   = 1'b1;
                    flush_c = 1'b1;
                    if (BR_PENALTY > 1) begin
                        state_d = FLUSH;
                        cnt_d   = BP_M1;
                    end
                end else if (ex_vec_mem) begin
                    start_c = 1'b1;
                    stall_c = 1'b1;
                    // a single-cycle op finishing with its own start never waits
                    if (!vec_done) begin
                        state_d = VWAIT;
                        cnt_d   = 8'd0;
                    end
                end else if (hz) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (LOAD_DELAY > 1) begin
                        state_d = LSTALL;
                        cnt_d   = LD_M1;
                    end
                end
            end
            LSTALL: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                cnt_d    = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end
            end
            FLUSH: begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                cnt_d    = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end
            end
            VWAIT: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (vec_done) begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= TO_M1) begin
                    err_set = 1'b1;
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (err_set)
                err_q <= 1'b1;
        end
    end

    // Mealy outputs are forced low while reset is held
    assign sel_sto     = sel_c & ~rst;
    assign stall_pc    = stall_c & ~rst;
    assign stall_if_id = stall_c & ~rst;
    assign flush_if_id = flush_c & ~rst;
    assign bubble_ex   = bubble_c & ~rst;
    assign vec_start   = start_c & ~rst;
    assign vec_err     = err_q;
    assign state_o     = state_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] sstall_q, sflush_q;
    logic        stall_ev, flush_ev;

    assign stall_ev = (state_q == LSTALL) | (state_q == VWAIT);
    assign flush_ev = (state_q == RUN) & ex_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sstall_q <= 16'd0;
            sflush_q <= 16'd0;
        end else begin
            if (stall_ev && sstall_q != 16'hFFFF)
                sstall_q <= sstall_q + 16'd1;
            if (flush_ev && sflush_q != 16'hFFFF)
                sflush_q <= sflush_q + 16'd1;
        end
    end

    assign stat_stall = sstall_q;
    assign stat_flush = sflush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level reference model.
// Stat counters are checked when HAZARD_STATS_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int LD = 3;
    localparam int BP = 2;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] id_rp = '0, id_rs = '0, ex_rg = '0;
    logic       id_use_rp = 0, id_use_rs = 0, ex_load = 0;
    logic       ex_taken = 0, ex_vec_mem = 0, vec_done = 0;
    logic       sel_sto, stall_pc, stall_if_id, flush_if_id;
    logic       bubble_ex, vec_start, vec_err;
    logic [1:0] state_o;
`ifdef HAZARD_STATS_EN
    logic [15:0] stat_stall, stat_flush;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .LOAD_DELAY (LD),
        .BR_PENALTY (BP),
        .VEC_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_rp      (id_rp),
        .id_rs      (id_rs),
        .id_use_rp  (id_use_rp),
        .id_use_rs  (id_use_rs),
        .ex_rg      (ex_rg),
        .ex_load    (ex_load),
        .ex_taken   (ex_taken),
        .ex_vec_mem (ex_vec_mem),
        .vec_done   (vec_done),
        .sel_sto    (sel_sto),
        .stall_pc   (stall_pc),
        .stall_if_id(stall_if_id),
        .flush_if_id(flush_if_id),
        .bubble_ex  (bubble_ex),
        .vec_start  (vec_start),
        .vec_err    (vec_err),
        .state_o    (state_o)
`ifdef HAZARD_STATS_EN
        ,
        .stat_stall (stat_stall),
        .stat_flush (stat_flush)
`endif
    );

    int n_pass = 0;
    int n_tot  = 0;

    // reference: mode 0 run, 1 load stall, 2 flush, 3 vector wait
    int m_mode = 0;
    int m_left = 0;
    int m_age  = 0;
    int m_err  = 0;
    int m_nstall = 0;
    int m_nflush = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] outs();
        return {23'd0, sel_sto, stall_pc, stall_if_id, flush_if_id,
                bubble_ex, vec_start, vec_err, state_o};
    endfunction

    function automatic logic [31:0] mk(input bit s, input bit st,
                                       input bit fl, input bit bu,
                                       input bit vs, input int err,
                                       input int mode);
        return {23'd0, s, st, st, fl, bu, vs, err[0], mode[1:0]};
    endfunction

    task automatic step(input bit t, input bit v, input bit l,
                        input bit d, input logic [3:0] rp,
                        input logic [3:0] rs, input logic [3:0] rg,
                        input bit urp, input bit urs);
        bit s, st, fl, bu, vs, hz;
        @(posedge clk);
        #1;
        ex_taken = t; ex_vec_mem = v; ex_load = l; vec_done = d;
        id_rp = rp; id_rs = rs; ex_rg = rg;
        id_use_rp = urp; id_use_rs = urs;
        @(negedge clk);
        hz = l && ((urp && rp == rg) || (urs && rs == rg));
        {s, st, fl, bu, vs} = '0;
        case (m_mode)
            0: if (t) {s, fl} = 2'b11;
               else if (v) {vs, st} = 2'b11;
               else if (hz) {st, bu} = 2'b11;
            1: {st, bu} = 2'b11;
            2: {fl, bu} = 2'b11;
            default: {st, bu} = 2'b11;
        endcase
        check("outs", outs(), mk(s, st, fl, bu, vs, m_err, m_mode));
`ifdef HAZARD_STATS_EN
        check("stat_stall", 32'(stat_stall), 32'(m_nstall));
        check("stat_flush", 32'(stat_flush), 32'(m_nflush));
`endif
        case (m_mode)
            0: begin
                if (t) begin
                    m_nflush++;
                    if (BP > 1) begin m_mode = 2; m_left = BP - 1; end
                end else if (v) begin
                    if (!d) begin m_mode = 3; m_age = 0; end
                end else if (hz && LD > 1) begin
                    m_mode = 1; m_left = LD - 1;
                end
            end
            1, 2: begin
                if (m_mode == 1) m_nstall++;
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            default: begin
                m_nstall++;
                if (d) m_mode = 0;
                else if (m_age == TO - 1) begin m_err = 1; m_mode = 0; end
                m_age++;
            end
        endcase
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        ex_taken = 1; ex_vec_mem = 1; ex_load = 1; vec_done = 0;
        id_use_rs = 1; id_rs = ex_rg;
        rst = 1;
        #1;
        check("rst_outs", outs(), 32'd0);
`ifdef HAZARD_STATS_EN
        check("rst_stat", {stat_stall, stat_flush}, 32'd0);
`endif
        @(negedge clk);
        {ex_taken, ex_vec_mem, ex_load, vec_done} = '0;
        {id_use_rp, id_use_rs} = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_mode = 0; m_left = 0; m_age = 0; m_err = 0;
        m_nstall = 0; m_nflush = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    endtask

    initial begin
        do_reset();
        // load-use on Rs
        step(0, 0, 1, 0, 4'd5, 4'd3, 4'd3, 0, 1);
        idle(4);
        // load-use on Rp, R0 compares like any register
        step(0, 0, 1, 0, 4'd0, 4'd9, 4'd0, 1, 0);
        idle(4);
        // taken branch
        step(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(3);
        // taken branch together with a hazard
        step(1, 0, 1, 0, 4'd3, 4'd3, 4'd3, 1, 1);
        idle(3);
        // vector op, done five cycles after start
        step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(4);
        step(0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(2);
        // vector op finishing in its start cycle
        step(0, 1, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(2);
        // vector op timing out, error stays set
        step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(TO + 4);
        step(0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(2);
        // reset in the middle of a vector wait
        step(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(3);
        do_reset();
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 4) < 2,
                 $urandom_range(0, 6) == 0,
                 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
